fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised successor to the switch's input-buffer FIFO: a synchronous single-clock FIFO with configurable width and depth, programmable almost-full/almost-empty thresholds, and a hysteretic pause output. It also provides an occupancy count and a sticky, encoded overflow/underflow error. It sits on each switch port between the link receiver and the arbiter. `fifo_pause` back-pressures the upstream sender.

## Interface
Parameters:
- DATA_SIZE, 10, word width in bits
- ADDR_SIZE, 3, pointer width; DEPTH = 2**ADDR_SIZE entries (8 by default)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- write  in  1  push request
- read  in  1  pop request
- data_in_push  in  DATA_SIZE  push data
- almost_full_in  in  ADDR_SIZE+1  almost-full / pause-set threshold
- almost_empty_in  in  ADDR_SIZE+1  almost-empty / pause-clear threshold
- data_out_pop  out  DATA_SIZE  pop data
- data_out_valid  out  1  data_out_pop holds a newly popped word
- fifo_count  out  ADDR_SIZE+1  occupancy, 0..DEPTH
- fifo_empty, fifo_full  out  1 each  count==0 / count==DEPTH
- fifo_almost_full  out  1  count >= almost_full_in
- fifo_almost_empty  out  1  count <= almost_empty_in
- fifo_pause  out  1  hysteretic back-pressure
- fifo_error  out  1  sticky; OR of error_code bits
- error_code  out  2  sticky {overflow, underflow}

## Operation
- Write acceptance:
  - wr_acc = write & (~full | rd_acc).
  - A write while full without an accepted read is dropped and sets error_code[1].
- Read acceptance:
  - rd_acc = read & ~empty.
  - A read while empty sets error_code[0]. data_out_pop holds its value and data_out_valid stays 0.
- Count and pointers:
  - count_next = count + wr_acc − rd_acc.
  - Pointers are ADDR_SIZE wide and wrap naturally modulo DEPTH.
- Simultaneous read and write:
  - When full: both are accepted; count is unchanged; no error.
  - When empty: the write is accepted and the read flags underflow (non-FWFT build); count becomes 1.
- Flags:
  - empty, full, almost_full and almost_empty are combinational from the registered count.
  - Thresholds are sampled live every cycle.
- fifo_pause register, evaluated on count_next each cycle:
  - Set if count_next >= almost_full_in.
  - Else clear if count_next <= almost_empty_in.
  - Else hold.
  - Set has priority if the thresholds are misprogrammed (almost_empty_in >= almost_full_in).
- error_code bits are sticky until reset.
- Reset values (reset=0 at a clock edge):
  - count 0; pointers 0.
  - data_out_pop 0; data_out_valid 0.
  - fifo_pause 0; error_code 2'b00; fifo_error 0.
  - Therefore fifo_empty 1, fifo_full 0; almost flags follow their formulas.
  - Memory contents are not reset.
  - read/write in the reset cycle are ignored.
  - A reset mid-operation discards all contents and clears the sticky errors.

## Timing
- Write latency: data pushed at edge N is poppable by a read sampled at edge N+1.
- Registered read (default build):
  - On an accepted read at edge N, data_out_pop updates at edge N and data_out_valid is 1 for that cycle.
  - data_out_valid returns to 0 after the next edge unless another read is accepted.
- count, flags and fifo_pause reflect all accepts at edge N immediately after edge N.
- error_code sets at the edge of the offending request.

## Configuration
- FIFO_FWFT_EN defined (first-word fall-through):
  - data_out_pop continuously shows the head entry.
  - data_out_valid = ~fifo_empty.
  - read acknowledges (consumes) the head.
  - A word written into an empty FIFO at edge N appears at the output after edge N.
  - A simultaneous read+write at empty is still an underflow.
- FIFO_FWFT_EN undefined: registered read as described under Timing.

## Structure
- Shared package fifo_pkg:
  - error_code bit indices ERR_UNDERFLOW=0 and ERR_OVERFLOW=1.
  - DEPTH / count-width derivation function.
- One sub-module, fifo_mem: DEPTH×DATA_SIZE register array with a synchronous write port and an asynchronous read port.
- fifo_param holds pointers, count, flags, pause and error logic.

## Test plan
All cases use DATA_SIZE=10, ADDR_SIZE=3, almost_full_in=6, almost_empty_in=2.
- Fill: reset, then write 0x001..0x008 on consecutive cycles → fifo_pause=1 after the 6th write; after the 8th, fifo_full=1, count=8, error_code=00.
- Overflow and ordering:
  - A 9th write (0x3FF) while full → dropped, count=8, error_code=10, fifo_error=1.
  - Then 8 reads → data_out_pop 0x001..0x008 in order, valid each cycle.
- Underflow: a read when empty → error_code bit0 set, data_out_valid=0, data_out_pop unchanged.
- Simultaneous read+write:
  - At count=8 → count stays 8, no new error.
  - At count=0 (non-FWFT) → count=1, underflow set.
- Hysteresis and thresholds:
  - Fill to 6 → pause=1.
  - Drain to 3 → pause still 1.
  - Drain to 2 → pause=0.
  - Write to 5 → pause stays 0.
  - Set almost_empty_in=7 at count 6 → pause=1 (set priority).
- Reset and FWFT:
  - Assert reset at count=5 with error set → next cycle count=0, fifo_empty=1, error_code=00.
  - With FIFO_FWFT_EN, write 0x155 into an empty FIFO → data_out_pop=0x155 and data_out_valid=1 the following cycle, without a read.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the parametrised switch-port FIFO.
//   ERR_UNDERFLOW / ERR_OVERFLOW : bit indices into error_code.
//   fifo_depth()                 : number of entries for a given pointer width.
//   count_width()                : width of an occupancy count able to hold 0..DEPTH.
package fifo_pkg;

    localparam int unsigned ERR_UNDERFLOW = 0;
    localparam int unsigned ERR_OVERFLOW  = 1;

    function automatic int unsigned fifo_depth(input int unsigned addr_size);
        return 32'd1 << addr_size;
    endfunction

    // One extra bit over the pointer so that a completely full FIFO is representable.
    function automatic int unsigned count_width(input int unsigned addr_size);
        return addr_size + 1;
    endfunction

endpackage

// File: rtl/fifo_param_if.sv
// fifo_param_if: handshake, data, threshold and status bundle of fifo_param.
//   master : upstream/arbiter side - drives write, read, data_in_push and thresholds,
//            observes data and status.
//   slave  : the FIFO itself.
// Signals: write, read, data_in_push[DATA_SIZE], almost_full_in/almost_empty_in[ADDR_SIZE+1],
//          data_out_pop[DATA_SIZE], data_out_valid, fifo_count[ADDR_SIZE+1], fifo_empty,
//          fifo_full, fifo_almost_full, fifo_almost_empty, fifo_pause, fifo_error,
//          error_code[2] = {overflow, underflow}.
interface fifo_param_if #(
    parameter int unsigned DATA_SIZE = 10,
    parameter int unsigned ADDR_SIZE = 3
);
    logic                 write;
    logic                 read;
    logic [DATA_SIZE-1:0] data_in_push;
    logic [ADDR_SIZE:0]   almost_full_in;
    logic [ADDR_SIZE:0]   almost_empty_in;
    logic [DATA_SIZE-1:0] data_out_pop;
    logic                 data_out_valid;
    logic [ADDR_SIZE:0]   fifo_count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_almost_full;
    logic                 fifo_almost_empty;
    logic                 fifo_pause;
    logic                 fifo_error;
    logic [1:0]           error_code;

    modport master (
        output write, read, data_in_push, almost_full_in, almost_empty_in,
        input  data_out_pop, data_out_valid, fifo_count, fifo_empty, fifo_full,
               fifo_almost_full, fifo_almost_empty, fifo_pause, fifo_error, error_code
    );

    modport slave (
        input  write, read, data_in_push, almost_full_in, almost_empty_in,
        output data_out_pop, data_out_valid, fifo_count, fifo_empty, fifo_full,
               fifo_almost_full, fifo_almost_empty, fifo_pause, fifo_error, error_code
    );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_SIZE register array, synchronous write, asynchronous read.
// Contents are deliberately not reset.
//   clk_i   : rising-edge clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : combinational read data at raddr_i
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 10,
    parameter int unsigned ADDR_SIZE = 3
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] waddr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    input  logic [ADDR_SIZE-1:0] raddr_i,
    output logic [DATA_SIZE-1:0] rdata_o
);
    localparam int unsigned DEPTH = fifo_depth(ADDR_SIZE);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_param.sv
// fifo_param: synchronous single-clock FIFO for a switch input port.
// Holds pointers, occupancy count, status flags, hysteretic pause and sticky errors;
// storage lives in fifo_mem.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : fifo_param_if.slave (push/pop handshake, thresholds, status)
// Build option: define FIFO_FWFT_EN for first-word fall-through output; otherwise
// data_out_pop is registered and updated by each accepted read.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 10,
    parameter int unsigned ADDR_SIZE = 3
) (
    input  logic         clk,
    input  logic         reset,
    fifo_param_if.slave  bus
);
    localparam int unsigned DEPTH = fifo_depth(ADDR_SIZE);
    localparam int unsigned CW    = count_width(ADDR_SIZE);

    typedef logic [CW-1:0]        cnt_t;
    typedef logic [ADDR_SIZE-1:0] ptr_t;

    ptr_t                 wr_ptr_q, wr_ptr_d;
    ptr_t                 rd_ptr_q, rd_ptr_d;
    cnt_t                 count_q, count_d;
    logic                 pause_q, pause_d;
    logic [1:0]           err_q, err_d;
    logic                 empty, full;
    logic                 rd_acc, wr_acc;
    logic [DATA_SIZE-1:0] mem_rdata;

    assign empty = (count_q == cnt_t'(0));
    assign full  = (count_q == cnt_t'(DEPTH));

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = bus.read & ~empty;
    assign wr_acc = bus.write & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        count_d  = count_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);

        // Set wins over clear so misprogrammed thresholds fail safe (paused).
        pause_d = pause_q;
        if (count_d >= bus.almost_full_in) begin
            pause_d = 1'b1;
        end else if (count_d <= bus.almost_empty_in) begin
            pause_d = 1'b0;
        end

        err_d = err_q;
        err_d[ERR_OVERFLOW]  = err_q[ERR_OVERFLOW] | (bus.write & ~wr_acc);
        err_d[ERR_UNDERFLOW] = err_q[ERR_UNDERFLOW] | (bus.read & empty);
    end

    fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc & reset),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_in_push),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pause_q  <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pause_q  <= pause_d;
            err_q    <= err_d;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is always visible; a read only advances the pointer.
    assign bus.data_out_pop   = mem_rdata;
    assign bus.data_out_valid = ~empty;
`else
    logic [DATA_SIZE-1:0] dout_q;
    logic                 dvalid_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dvalid_q <= rd_acc;
            if (rd_acc) begin
                dout_q <= mem_rdata;
            end
        end
    end

    assign bus.data_out_pop   = dout_q;
    assign bus.data_out_valid = dvalid_q;
`endif

    assign bus.fifo_count        = count_q;
    assign bus.fifo_empty        = empty;
    assign bus.fifo_full         = full;
    assign bus.fifo_almost_full  = (count_q >= bus.almost_full_in);
    assign bus.fifo_almost_empty = (count_q <= bus.almost_empty_in);
    assign bus.fifo_pause        = pause_q;
    assign bus.error_code        = err_q;
    assign bus.fifo_error        = |err_q;
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed plus randomized stimulus for fifo_param, checked against a
// queue-based reference model after every clock edge.
module tb_fifo_param;
    localparam int DS    = 10;
    localparam int AS    = 3;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fifo_param_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) bus ();

    fifo_param #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DS-1:0] q[$];
    logic [1:0]    m_err   = 2'b00;
    logic          m_pause = 1'b0;
    logic [DS-1:0] m_dout  = '0;
    logic          m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model using the inputs currently on the bus.
    task automatic model_edge();
        int n;
        bit rd;
        bit wr;
        logic [DS-1:0] popped;
        if (!rst_n) begin
            q.delete();
            m_err   = 2'b00;
            m_pause = 1'b0;
            m_dout  = '0;
            m_valid = 1'b0;
        end else begin
            n  = q.size();
            rd = bus.read && (n != 0);
            wr = bus.write && ((n != DEPTH) || rd);
            if (bus.read && n == 0) m_err[0] = 1'b1;
            if (bus.write && !wr)   m_err[1] = 1'b1;
            m_valid = rd;
            if (rd) begin
                popped = q.pop_front();
                m_dout = popped;
            end
            if (wr) q.push_back(bus.data_in_push);
            n = q.size();
            if (n >= int'(bus.almost_full_in))       m_pause = 1'b1;
            else if (n <= int'(bus.almost_empty_in)) m_pause = 1'b0;
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = q.size();
        chk({ctx, ".count"}, 32'(bus.fifo_count), 32'(n));
        chk({ctx, ".empty"}, 32'(bus.fifo_empty), 32'(n == 0));
        chk({ctx, ".full"}, 32'(bus.fifo_full), 32'(n == DEPTH));
        chk({ctx, ".afull"}, 32'(bus.fifo_almost_full), 32'(n >= int'(bus.almost_full_in)));
        chk({ctx, ".aempty"}, 32'(bus.fifo_almost_empty),
            32'(n <= int'(bus.almost_empty_in)));
        chk({ctx, ".pause"}, 32'(bus.fifo_pause), 32'(m_pause));
        chk({ctx, ".errcode"}, 32'(bus.error_code), 32'(m_err));
        chk({ctx, ".ferror"}, 32'(bus.fifo_error), 32'(|m_err));
`ifdef FIFO_FWFT_EN
        chk({ctx, ".valid"}, 32'(bus.data_out_valid), 32'(n != 0));
        if (n != 0) chk({ctx, ".dout"}, 32'(bus.data_out_pop), 32'(q[0]));
`else
        chk({ctx, ".valid"}, 32'(bus.data_out_valid), 32'(m_valid));
        chk({ctx, ".dout"}, 32'(bus.data_out_pop), 32'(m_dout));
`endif
    endtask

    task automatic step(input string ctx, input logic w, input logic r, input logic [DS-1:0] d);
        bus.write        = w;
        bus.read         = r;
        bus.data_in_push = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step("reset", 1'b1, 1'b1, 10'h2AA);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.write           = 1'b0;
        bus.read            = 1'b0;
        bus.data_in_push    = '0;
        bus.almost_full_in  = 4'd6;
        bus.almost_empty_in = 4'd2;

        do_reset();
        do_reset();

        // Fill 0x001..0x008
        for (int i = 1; i <= 8; i++) begin
            step("fill", 1'b1, 1'b0, DS'(i));
            if (i == 5) chk("plan.pause_before6", 32'(bus.fifo_pause), 32'd0);
            if (i == 6) chk("plan.pause_at6", 32'(bus.fifo_pause), 32'd1);
        end
        chk("plan.full8", 32'(bus.fifo_full), 32'd1);
        chk("plan.err_none", 32'(bus.error_code), 32'd0);

        // Overflow, then drain in order
        step("ovf", 1'b1, 1'b0, 10'h3FF);
        chk("plan.ovf_code", 32'(bus.error_code), 32'd2);
        for (int i = 1; i <= 8; i++) begin
            step("drain", 1'b0, 1'b1, '0);
`ifndef FIFO_FWFT_EN
            chk("plan.drain_data", 32'(bus.data_out_pop), 32'(i));
`endif
        end

        // Underflow
        step("udf", 1'b0, 1'b1, '0);
        chk("plan.udf_code", 32'(bus.error_code), 32'd3);

        // Simultaneous read+write at full, then at empty
        do_reset();
        for (int i = 0; i < 8; i++) step("fill2", 1'b1, 1'b0, DS'($urandom));
        step("rw_full", 1'b1, 1'b1, 10'h123);
        chk("plan.rw_full_cnt", 32'(bus.fifo_count), 32'd8);
        do_reset();
        step("rw_empty", 1'b1, 1'b1, 10'h0AB);
        chk("plan.rw_empty_cnt", 32'(bus.fifo_count), 32'd1);

        // Hysteresis
        do_reset();
        for (int i = 0; i < 6; i++) step("hyst_up", 1'b1, 1'b0, DS'($urandom));
        for (int i = 0; i < 3; i++) step("hyst_dn", 1'b0, 1'b1, '0);
        chk("plan.pause_at3", 32'(bus.fifo_pause), 32'd1);
        step("hyst_dn2", 1'b0, 1'b1, '0);
        chk("plan.pause_at2", 32'(bus.fifo_pause), 32'd0);
        for (int i = 0; i < 3; i++) step("hyst_up5", 1'b1, 1'b0, DS'($urandom));
        chk("plan.pause_at5", 32'(bus.fifo_pause), 32'd0);
        step("hyst_up6", 1'b1, 1'b0, DS'($urandom));
        bus.almost_empty_in = 4'd7;
        step("misprog", 1'b0, 1'b0, '0);
        chk("plan.misprog_pause", 32'(bus.fifo_pause), 32'd1);
        bus.almost_empty_in = 4'd2;

        // Reset mid-operation with an error set
        do_reset();
        step("err", 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) step("to5", 1'b1, 1'b0, DS'($urandom));
        do_reset();
        chk("plan.rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("plan.rst_code", 32'(bus.error_code), 32'd0);

        // Write into empty FIFO (fall-through visible without a read in FWFT builds)
        step("push155", 1'b1, 1'b0, 10'h155);
        step("idle", 1'b0, 1'b0, '0);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                bus.almost_full_in  = 4'($urandom_range(0, 9));
                bus.almost_empty_in = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                step("rand", 1'($urandom), 1'($urandom), DS'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
